// File: rtl/toy_dmem_resp.sv
// -----------------------------------------------------------------------------
// toy_dmem_resp
//
// Single-port data memory with a one-cycle registered read response.
// After reset it can zero-sweep the whole array before accepting traffic.
//
// Parameters
//   AW          number of word-address bits implemented (depth = 2^AW words)
//   INIT_CLEAR  1: zero-sweep memory after reset; 0: start servicing at once
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   DREQ       one-cycle access request from the core
//   DRW        access direction (1 = write, 0 = read)
//   DADDR      30-bit word address
//   DWDATA     32-bit write data
//   DRDATA     registered read data
//   INIT_DONE  high once the sweep has finished and accesses are serviced
//   ERR        sticky out-of-range access flag (cleared only by reset)
// -----------------------------------------------------------------------------
module toy_dmem_resp #(
  parameter int AW         = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        INIT_DONE,
  output logic        ERR
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_RUN;

  state_t          state_reg, state_next;
  logic [AW-1:0]   sweep_reg, sweep_next;
  logic [31:0]     rdata_reg;
  logic            err_reg, err_next;

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic            rd_load;   // in-range read: capture memory word
  logic            rd_zero;   // out-of-range read: return zero

  logic            in_range;
  logic [AW-1:0]   index;

  logic [31:0]     mem [0:DEPTH-1];

  assign index = DADDR[AW-1:0];

  // Upper address bits must be zero; when the full address is implemented
  // every address is in range.
  generate
    if (AW < 30) begin : g_range
      assign in_range = (DADDR[29:AW] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  // Next-state and datapath control
  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    err_next   = err_reg;
    mem_we     = 1'b0;
    mem_addr   = index;
    mem_wdata  = DWDATA;
    rd_load    = 1'b0;
    rd_zero    = 1'b0;

    case (state_reg)
      ST_CLEAR: begin
        // Requests are ignored entirely while sweeping.
        mem_we    = 1'b1;
        mem_addr  = sweep_reg;
        mem_wdata = '0;
        if (&sweep_reg) begin
          // Last word cleared on this edge; counter holds instead of wrapping.
          state_next = ST_RUN;
        end else begin
          sweep_next = sweep_reg + AW'(1);
        end
      end
      ST_RUN: begin
        if (DREQ) begin
          if (in_range) begin
            if (DRW) mem_we  = 1'b1;
            else     rd_load = 1'b1;
          end else begin
            err_next = 1'b1;
            if (!DRW) rd_zero = 1'b1;
          end
        end
      end
      default: state_next = RESET_STATE;
    endcase

    // Reset wins over any access or sweep write in the same cycle.
    if (RST) begin
      mem_we  = 1'b0;
      rd_load = 1'b0;
      rd_zero = 1'b0;
    end
  end

  // Control and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= RESET_STATE;
      sweep_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
      err_reg   <= err_next;
      if (rd_load)      rdata_reg <= mem[index];
      else if (rd_zero) rdata_reg <= '0;
    end
  end

  // Memory write port (no reset so the array maps onto block RAM)
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign DRDATA    = rdata_reg;
  assign ERR       = err_reg;
  assign INIT_DONE = (state_reg == ST_RUN);

endmodule
